// File: rtl/load_store_unit.sv
// Load/store initiator between the EX/MEM boundary and data_mem, with a ready/valid response channel.
// Optional build macro LSU_MISALIGN_SPLIT_EN: misaligned loads become two aligned LW reads.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_misaligned
);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, ISSUE_HI, CAPTURE_HI} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
`endif

  state_t state, state_d;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              fault_q;
  logic [31:0]       rdata_q;

  logic illegal_f3, misaligned, req_fault, do_split, accept;

  always_comb begin
    if (req_we) illegal_f3 = (req_funct3 > 3'b010);
    else        illegal_f3 = (req_funct3 inside {3'b011, 3'b110, 3'b111});
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q;
  logic [31:0]       lo_q;
  logic [ADDR_W-1:0] addr_lo, addr_hi;
  logic [63:0]       pair;
  logic [31:0]       shifted, split_result;

  assign do_split = !req_we && !illegal_f3 && misaligned;
  assign addr_lo  = {addr_q[ADDR_W-1:2], 2'b00};
  assign addr_hi  = addr_lo + ADDR_W'(4);

  always_comb begin
    pair    = {mem_read_data, lo_q};
    shifted = 32'(pair >> {addr_q[1:0], 3'b000});
    case (f3_q)
      3'b000:  split_result = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  split_result = {24'd0, shifted[7:0]};
      3'b001:  split_result = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  split_result = {16'd0, shifted[15:0]};
      default: split_result = shifted;
    endcase
  end
`else
  assign do_split = 1'b0;
`endif

  assign req_fault = illegal_f3 || (misaligned && !do_split);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d        = state;
    req_ready      = (state == IDLE) && !rst;
    rsp_valid      = (state == RESP);
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_funct3     = '0;
    case (state)
      IDLE: if (accept) state_d = req_fault ? RESP : ISSUE;
      ISSUE: begin
        mem_address    = addr_q;
        mem_funct3     = f3_q;
        mem_write_data = wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_q) begin
          mem_address = addr_lo;
          mem_funct3  = 3'b010;
        end
`endif
        if (we_q) begin
          mem_write_en = !mem_misaligned;
          state_d      = RESP;
        end else begin
          mem_read_en = 1'b1;
          state_d     = CAPTURE;
        end
      end
      CAPTURE: begin
        mem_read_en = 1'b1;
        mem_address = addr_q;
        mem_funct3  = f3_q;
        state_d     = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_q) begin
          mem_address = addr_lo;
          mem_funct3  = 3'b010;
          state_d     = ISSUE_HI;
        end
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ISSUE_HI: begin
        mem_read_en = 1'b1;
        mem_address = addr_hi;
        mem_funct3  = 3'b010;
        state_d     = CAPTURE_HI;
      end
      CAPTURE_HI: begin
        mem_read_en = 1'b1;
        mem_address = addr_hi;
        mem_funct3  = 3'b010;
        state_d     = RESP;
      end
`endif
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q <= 1'b0;
      lo_q    <= '0;
`endif
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (accept) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          fault_q <= req_fault;
          rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_q <= do_split;
`endif
        end
        ISSUE: if (mem_misaligned) fault_q <= 1'b1;
        CAPTURE: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) lo_q <= mem_read_data;
          else
`endif
          rdata_q <= fault_q ? 32'd0 : mem_read_data;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        CAPTURE_HI: rdata_q <= fault_q ? 32'd0 : split_result;
`endif
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data_mem (registered read, extension on read).
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_read_en, mem_write_en, mem_misaligned;
  logic [31:0] mem_address, mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic [2:0]  mem_funct3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_funct3(mem_funct3),
    .mem_read_data(mem_read_data), .mem_misaligned(mem_misaligned)
  );

  // data_mem stand-in: 64 bytes indexed by address[5:0]
  bit [7:0] mem [64];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    rd_word = {mem[6'(a + 32'd3)], mem[6'(a + 32'd2)], mem[6'(a + 32'd1)], mem[6'(a)]};
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  ext = {{24{w[7]}}, w[7:0]};
      3'b100:  ext = {24'd0, w[7:0]};
      3'b001:  ext = {{16{w[15]}}, w[15:0]};
      3'b101:  ext = {16'd0, w[15:0]};
      default: ext = w;
    endcase
  endfunction

  always_comb begin
    mem_misaligned = 1'b0;
    if (mem_read_en || mem_write_en)
      case (mem_funct3[1:0])
        2'b01:   mem_misaligned = mem_address[0];
        2'b10:   mem_misaligned = |mem_address[1:0];
        default: mem_misaligned = 1'b0;
      endcase
  end

  int          wr_cnt = 0, rd_cnt = 0;
  logic [31:0] last_wr_addr = '0, last_wr_data = '0;
  logic [31:0] rd_log [$];

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[6'(mem_address)] <= mem_write_data[7:0];
      if (mem_funct3[1:0] != 2'b00) mem[6'(mem_address + 32'd1)] <= mem_write_data[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        mem[6'(mem_address + 32'd2)] <= mem_write_data[23:16];
        mem[6'(mem_address + 32'd3)] <= mem_write_data[31:24];
      end
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mem_address;
      last_wr_data <= mem_write_data;
    end
    if (mem_read_en) begin
      mem_read_data <= ext(rd_word(mem_address), mem_funct3);
      rd_cnt        <= rd_cnt + 1;
      rd_log.push_back(mem_address);
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb [$];

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_fault, input int exp_lat, input int stall,
                        input string name);
    exp_t e;
    int   n, lat, acc0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s accept: req_ready=%b required 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{exp_rdata, exp_fault, exp_lat, name});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    e = sb.pop_front();
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s rsp_timeout: rsp_valid=%b required 1 within 50 cycles", e.name, rsp_valid);
      return;
    end
    tests++;
    if (lat != e.lat) begin
      fails++; $display("FAIL %s latency: got %0d required %0d", e.name, lat, e.lat);
    end
    tests++;
    if (rsp_rdata !== e.rdata) begin
      fails++; $display("FAIL %s rdata: got %h required %h", e.name, rsp_rdata, e.rdata);
    end
    tests++;
    if (rsp_fault !== e.fault) begin
      fails++; $display("FAIL %s fault: got %b required %b", e.name, rsp_fault, e.fault);
    end
    acc0 = rd_cnt + wr_cnt;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_fault !== e.fault || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s stall%0d: valid=%b rdata=%h fault=%b req_ready=%b required 1/%h/%b/0",
                 e.name, s, rsp_valid, rsp_rdata, rsp_fault, req_ready, e.rdata, e.fault);
      end
    end
    req_valid = 1'b0;
    if (stall > 0) begin
      tests++;
      if (rd_cnt + wr_cnt != acc0) begin
        fails++; $display("FAIL %s stall_mem: %0d accesses during stall, required 0", e.name, rd_cnt + wr_cnt - acc0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s after_handshake: req_ready=%b rsp_valid=%b required 1/0", e.name, req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({req_ready, rsp_valid, rsp_fault, mem_read_en, mem_write_en} !== 5'b0 || rsp_rdata !== 32'd0 ||
        mem_address !== 32'd0 || mem_write_data !== 32'd0 || mem_funct3 !== 3'd0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b valid=%b fault=%b rdata=%h rd=%b wr=%b addr=%h required all 0",
               req_ready, rsp_valid, rsp_fault, rsp_rdata, mem_read_en, mem_write_en, mem_address);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_store_load();
    int w0;
    w0 = wr_cnt;
    do_req(1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, "sw_4");
    tests++;
    if (wr_cnt - w0 != 1 || last_wr_addr !== 32'h4 || last_wr_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sw_write_pulse: cycles=%0d addr=%h data=%h required 1/00000004/deadbeef",
               wr_cnt - w0, last_wr_addr, last_wr_data);
    end
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, "lw_4");
  endtask

  task automatic test_byte_half();
    do_req(1'b1, 3'b000, 32'h1, 32'h555555AA, 32'h0,        1'b0, 2, 0, "sb_1");
    do_req(1'b0, 3'b000, 32'h1, 32'h0,        32'hFFFFFFAA, 1'b0, 3, 0, "lb_1");
    do_req(1'b0, 3'b100, 32'h1, 32'h0,        32'h000000AA, 1'b0, 3, 0, "lbu_1");
    do_req(1'b1, 3'b001, 32'h2, 32'h00001234, 32'h0,        1'b0, 2, 0, "sh_2");
    do_req(1'b0, 3'b001, 32'h2, 32'h0,        32'h00001234, 1'b0, 3, 0, "lh_2");
    do_req(1'b0, 3'b101, 32'h2, 32'h0,        32'h00001234, 1'b0, 3, 0, "lhu_2");
  endtask

  task automatic test_fault();
    int a0;
    a0 = rd_cnt + wr_cnt;
`ifndef LSU_MISALIGN_SPLIT_EN
    do_req(1'b0, 3'b010, 32'h1, 32'h0,        32'h0, 1'b1, 1, 0, "lw_misaligned");
`endif
    do_req(1'b1, 3'b001, 32'h3, 32'h0000BEEF, 32'h0, 1'b1, 1, 0, "sh_misaligned");
    do_req(1'b1, 3'b010, 32'h2, 32'h12345678, 32'h0, 1'b1, 1, 0, "sw_misaligned");
    do_req(1'b0, 3'b011, 32'h0, 32'h0,        32'h0, 1'b1, 1, 0, "load_f3_011");
    do_req(1'b0, 3'b110, 32'h0, 32'h0,        32'h0, 1'b1, 1, 0, "load_f3_110");
    do_req(1'b1, 3'b100, 32'h0, 32'h0,        32'h0, 1'b1, 1, 0, "store_f3_100");
    tests++;
    if (rd_cnt + wr_cnt != a0) begin
      fails++; $display("FAIL fault_no_access: %0d memory enables seen, required 0", rd_cnt + wr_cnt - a0);
    end
  endtask

`ifdef LSU_MISALIGN_SPLIT_EN
  task automatic test_split();
    int i0;
    do_req(1'b1, 3'b010, 32'h0,        32'h44332211, 32'h0, 1'b0, 2, 0, "sw_0");
    do_req(1'b1, 3'b010, 32'h4,        32'h88776655, 32'h0, 1'b0, 2, 0, "sw_4b");
    do_req(1'b1, 3'b010, 32'hFFFFFFFC, 32'hCCBBAA99, 32'h0, 1'b0, 2, 0, "sw_top");
    do_req(1'b0, 3'b010, 32'h3, 32'h0, 32'h77665544, 1'b0, 5, 0, "split_lw_3");
    do_req(1'b0, 3'b001, 32'h3, 32'h0, 32'h00005544, 1'b0, 5, 0, "split_lh_3");
    do_req(1'b0, 3'b001, 32'h1, 32'h0, 32'h00003322, 1'b0, 5, 0, "split_lh_1");
    i0 = rd_log.size();
    do_req(1'b0, 3'b010, 32'hFFFFFFFD, 32'h0, 32'h11CCBBAA, 1'b0, 5, 0, "split_lw_wrap");
    tests++;
    if (rd_log.size() - i0 != 4) begin
      fails++; $display("FAIL split_wrap_reads: %0d read cycles, required 4", rd_log.size() - i0);
    end else begin
      tests++;
      if (rd_log[i0] !== 32'hFFFFFFFC || rd_log[i0+2] !== 32'h0) begin
        fails++;
        $display("FAIL split_wrap_addr: lo=%h hi=%h required fffffffc/00000000", rd_log[i0], rd_log[i0+2]);
      end
    end
  endtask
`endif

  task automatic test_stall();
    do_req(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0,        1'b0, 2, 0, "sw_20");
    do_req(1'b0, 3'b010, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0, 3, 5, "lw_20_stall");
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 3'b010, 32'h10, 32'h11111111, 32'h0,        1'b0, 2, 0, "b2b_sw_10");
    do_req(1'b1, 3'b010, 32'h14, 32'h22222222, 32'h0,        1'b0, 2, 0, "b2b_sw_14");
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'h11111111, 1'b0, 3, 0, "b2b_lw_10");
    do_req(1'b0, 3'b010, 32'h14, 32'h0,        32'h22222222, 1'b0, 3, 0, "b2b_lw_14");
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_read_en !== 1'b1) begin
      fails++; $display("FAIL midrst_capture: mem_read_en=%b required 1", mem_read_en);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_fault, mem_read_en, mem_write_en} !== 5'b0 || rsp_rdata !== 32'd0 ||
        mem_address !== 32'd0 || mem_write_data !== 32'd0 || mem_funct3 !== 3'd0) begin
      fails++;
      $display("FAIL midrst_outputs: ready=%b valid=%b fault=%b rdata=%h rd=%b wr=%b addr=%h required all 0",
               req_ready, rsp_valid, rsp_fault, rsp_rdata, mem_read_en, mem_write_en, mem_address);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_release: req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
    end
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, "lw_after_reset");
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_half();
    test_fault();
`ifdef LSU_MISALIGN_SPLIT_EN
    test_split();
`endif
    test_stall();
    test_back_to_back();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for `data_mem`. It accepts one load or store per handshake from the execute stage and drives the `data_mem` port (`read_en`/`write_en`/`address`/`write_data`/`funct3`). It captures the registered read data and returns a result or fault to writeback over a ready/valid response channel. The block sits between the EX/MEM pipeline boundary and `data_mem`.

## Interface
Parameters:
- `ADDR_W`, 32, address width; `data_mem` port width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code.
- `req_addr` in 32, `req_wdata` in 32: byte address and store data (low bytes used).
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_rdata` out 32: load result, extended per funct3; 0 for stores and faults.
- `rsp_fault` out 1: misaligned or illegal-funct3 access.
- `mem_read_en`, `mem_write_en` out 1; `mem_address` out 32; `mem_write_data` out 32; `mem_funct3` out 3: drive `data_mem`.
- `mem_read_data` in 32; `mem_misaligned` in 1: from `data_mem`.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP. The optional split path adds ISSUE_HI and CAPTURE_HI.
- **IDLE**
  - `req_ready` = 1 (forced 0 while `rst` is high).
  - On `req_valid && req_ready`, latch we/funct3/addr/wdata.
  - Legality check:
    - Illegal funct3 for loads: 011, 110, 111.
    - Illegal funct3 for stores: any value above 010.
    - Misaligned: halfword with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - Illegal or misaligned → RESP with fault, no memory access.
  - Otherwise → ISSUE.
- **ISSUE**
  - Drive `mem_address`/`mem_funct3`/`mem_write_data` from the latched values.
  - Store: `mem_write_en` = 1 for exactly this cycle → RESP.
  - Load: `mem_read_en` = 1 → CAPTURE.
  - `mem_misaligned` = 1 in ISSUE sets the fault flag. The store write is still suppressed; `mem_write_en` is gated by `!mem_misaligned`.
- **CAPTURE**
  - `mem_read_en` and the address are held.
  - `rsp_rdata` is registered from `mem_read_data` at the end of the cycle → RESP.
- **RESP**
  - `rsp_valid` = 1; `rsp_rdata`/`rsp_fault` stay stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready` → IDLE.
- When not in ISSUE/CAPTURE, all `mem_*` outputs are 0.
- Extension is performed by `data_mem` on normal loads. The LSU passes `rsp_rdata` through unchanged.
- Reset asserted mid-operation returns to IDLE immediately and drops all `mem_*` enables. A store not yet clocked into memory is lost.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready` 0 while `rst` is high, 1 after release.
  - `rsp_valid` 0, `rsp_rdata` 0, `rsp_fault` 0, all `mem_*` 0.
- Cycle 0 is the accept edge. Latency from accept to `rsp_valid`:
  - Store: ISSUE in cycle 1, `rsp_valid` in cycle 2.
  - Load: ISSUE cycle 1, CAPTURE cycle 2, `rsp_valid` in cycle 3.
  - Fault: `rsp_valid` in cycle 1.
  - Split load: `rsp_valid` in cycle 5.
- Response stall: `rsp_ready` held low keeps RESP indefinitely, and no new request is accepted.
- Back-to-back throughput: the next accept can occur in the cycle after the response handshake.
- `req_*` inputs are ignored outside IDLE.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined:
  - Misaligned loads are split instead of faulting. Legal-funct3 loads only.
  - ISSUE/CAPTURE perform LW (`mem_funct3` = 010) at `addr & ~3`.
  - ISSUE_HI/CAPTURE_HI perform LW at `(addr & ~3) + 4`, wrapping modulo 2^32.
  - Result: `{hi,lo} >> (8*addr[1:0])`, then low byte/half/word selected and sign- or zero-extended per the latched funct3.
  - Misaligned stores still fault.
- Macro undefined: every misaligned access faults. No split states are synthesized.

## Test plan
- Reset mid-load, asserted in CAPTURE:
  - Outputs all 0, state IDLE.
  - `req_ready` = 1 one cycle after release.
- SW 0xDEADBEEF @0x4, then LW @0x4:
  - `mem_write_en` pulses for 1 cycle.
  - Store `rsp_valid` at cycle 2.
  - Load returns 0xDEADBEEF at cycle 3 with fault 0.
- SB 0xAA @0x1:
  - LB @0x1 → 0xFFFFFFAA.
  - LBU @0x1 → 0x000000AA.
  - SH 0x1234 @0x2 then LH/LHU → 0x00001234.
- LW @0x1 and SH @0x3, macro off:
  - Both give `rsp_fault` = 1, `rsp_rdata` = 0, `rsp_valid` at cycle 1.
  - No `mem_*` enable ever asserted.
- Macro on; memory holds 0x44332211 @0x0 and 0x88776655 @0x4:
  - LW @0x3 → 0x77665544.
  - LH @0x3 → 0x00005544.
  - LW @0xFFFFFFFD reads 0xFFFFFFFC then 0x00000000.
- Hold `rsp_ready` = 0 for 5 cycles after a load:
  - `rsp_valid`/`rsp_rdata` are stable throughout.
  - `req_ready` = 0 throughout, and a new `req_valid` is ignored until the handshake.
